// File: rtl/hnoc_pkg.sv
// hnoc_pkg: shared flit layout, default widths and flit helpers for the hierarchical NoC.
package hnoc_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDR_WIDTH    = 3;
  localparam int PAYLOAD_WIDTH = DATA_WIDTH - ADDR_WIDTH;
  localparam int DEST_MSB      = DATA_WIDTH - 1;
  localparam int DEST_LSB      = DATA_WIDTH - ADDR_WIDTH;
  localparam int CNT_WIDTH     = 8;

  typedef logic [DATA_WIDTH-1:0]    flit_t;
  typedef logic [ADDR_WIDTH-1:0]    dest_t;
  typedef logic [PAYLOAD_WIDTH-1:0] payload_t;

  // Destination sits in the top bits; the payload travels unmodified below it.
  function automatic flit_t flit_pack(input dest_t dest, input payload_t payload);
    return {dest, payload};
  endfunction

  function automatic dest_t flit_dest(input flit_t flit);
    return flit[DEST_MSB -: ADDR_WIDTH];
  endfunction

endpackage

// File: rtl/hnoc_pe_adapter_if.sv
// hnoc_pe_adapter_if: PE-side and switch-side valid/ready channels of one leaf adapter.
interface hnoc_pe_adapter_if
  import hnoc_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int AddrWidth = ADDR_WIDTH
);

  localparam int PayloadWidth = DataWidth - AddrWidth;

  logic [PayloadWidth-1:0] i_pe_tx_payload;
  logic [AddrWidth-1:0]    i_pe_tx_dest;
  logic                    i_pe_tx_valid;
  logic                    o_pe_tx_ready;

  logic [DataWidth-1:0]    o_noc_data;
  logic                    o_noc_data_valid;
  logic                    i_noc_data_ready;

  logic [DataWidth-1:0]    i_noc_data;
  logic                    i_noc_data_valid;
  logic                    o_noc_data_ready;

  logic [PayloadWidth-1:0] o_pe_rx_payload;
  logic                    o_pe_rx_src_ok;
  logic                    o_pe_rx_valid;
  logic                    i_pe_rx_ready;

  logic [CNT_WIDTH-1:0]    o_misroute_cnt;

  // Adapter view.
  modport slave (
    input  i_pe_tx_payload, i_pe_tx_dest, i_pe_tx_valid,
    output o_pe_tx_ready,
    output o_noc_data, o_noc_data_valid,
    input  i_noc_data_ready,
    input  i_noc_data, i_noc_data_valid,
    output o_noc_data_ready,
    output o_pe_rx_payload, o_pe_rx_src_ok, o_pe_rx_valid,
    input  i_pe_rx_ready,
    output o_misroute_cnt
  );

  // PE + switch (environment) view.
  modport master (
    output i_pe_tx_payload, i_pe_tx_dest, i_pe_tx_valid,
    input  o_pe_tx_ready,
    input  o_noc_data, o_noc_data_valid,
    output i_noc_data_ready,
    output i_noc_data, i_noc_data_valid,
    input  o_noc_data_ready,
    input  o_pe_rx_payload, o_pe_rx_src_ok, o_pe_rx_valid,
    output i_pe_rx_ready,
    input  o_misroute_cnt
  );

endinterface

// File: rtl/hnoc_sync_fifo.sv
// hnoc_sync_fifo: single-clock FIFO with extended pointers; head is read straight from storage.
module hnoc_sync_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [Width-1:0] o_head
);

  localparam int IdxW = $clog2(Depth);
  localparam int PtrW = IdxW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = i_push && !o_full;
    do_pop   = i_pop && !o_empty;
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[IdxW-1:0]] <= i_data;
  end

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign o_head  = mem_q[rd_ptr_q[IdxW-1:0]];

endmodule

// File: rtl/hnoc_pe_adapter.sv
// hnoc_pe_adapter: PE <-> leaf-port network interface with flit buffering, address filtering and
// a saturating misroute counter. Define HNOC_LOOPBACK_EN to send self-addressed TX flits straight to RX.
module hnoc_pe_adapter
  import hnoc_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int AddrWidth = ADDR_WIDTH,
  parameter int MyAddr    = 0,
  parameter int FifoDepth = 4
) (
  input logic              i_clk,
  input logic              i_reset,
  hnoc_pe_adapter_if.slave bus
);

  localparam int PayloadWidth = DataWidth - AddrWidth;

  logic                 rdy_en_q, rdy_en_d;
  logic [CNT_WIDTH-1:0] misroute_cnt_q, misroute_cnt_d;

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DataWidth-1:0] tx_flit, tx_head;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DataWidth-1:0] rx_wdata, rx_head;

  logic                 pe_tx_ready, pe_tx_xfer;
  logic                 noc_in_ready, noc_in_xfer;
  logic                 rx_local, rx_deliver, rx_drop;
`ifdef HNOC_LOOPBACK_EN
  logic                 tx_self;
`endif

  // NOTE: every always_comb output gets a value before any branch, so no latch can form.
  always_comb begin
    rdy_en_d     = 1'b1;
    tx_flit      = flit_pack(bus.i_pe_tx_dest, bus.i_pe_tx_payload);
    noc_in_ready = rdy_en_q && !rx_full;
    noc_in_xfer  = bus.i_noc_data_valid && noc_in_ready;
`ifdef HNOC_LOOPBACK_EN
    // A self-addressed flit shares the RX write port with the network; the network wins.
    tx_self      = (bus.i_pe_tx_dest == AddrWidth'(MyAddr));
    pe_tx_ready  = rdy_en_q && (tx_self ? (!rx_full && !noc_in_xfer) : !tx_full);
    pe_tx_xfer   = bus.i_pe_tx_valid && pe_tx_ready;
    tx_push      = pe_tx_xfer && !tx_self;
    rx_push      = noc_in_xfer || (pe_tx_xfer && tx_self);
    rx_wdata     = noc_in_xfer ? bus.i_noc_data : tx_flit;
`else
    pe_tx_ready  = rdy_en_q && !tx_full;
    pe_tx_xfer   = bus.i_pe_tx_valid && pe_tx_ready;
    tx_push      = pe_tx_xfer;
    rx_push      = noc_in_xfer;
    rx_wdata     = bus.i_noc_data;
`endif
    tx_pop       = !tx_empty && bus.i_noc_data_ready;

    // A foreign head is dropped unconditionally, one per cycle, without a PE handshake.
    rx_local     = (flit_dest(rx_head) == AddrWidth'(MyAddr));
    rx_deliver   = !rx_empty && rx_local;
    rx_drop      = !rx_empty && !rx_local;
    rx_pop       = rx_drop || (rx_deliver && bus.i_pe_rx_ready);

    misroute_cnt_d = misroute_cnt_q;
    if (rx_drop && (misroute_cnt_q != '1)) misroute_cnt_d = misroute_cnt_q + CNT_WIDTH'(1);
  end

  // Readies stay low through reset and rise on the first edge that sees reset released.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rdy_en_q       <= 1'b0;
      misroute_cnt_q <= '0;
    end else begin
      rdy_en_q       <= rdy_en_d;
      misroute_cnt_q <= misroute_cnt_d;
    end
  end

  hnoc_sync_fifo #(
    .Width (DataWidth),
    .Depth (FifoDepth)
  ) u_tx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (tx_push),
    .i_data  (tx_flit),
    .i_pop   (tx_pop),
    .o_full  (tx_full),
    .o_empty (tx_empty),
    .o_head  (tx_head)
  );

  hnoc_sync_fifo #(
    .Width (DataWidth),
    .Depth (FifoDepth)
  ) u_rx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (rx_push),
    .i_data  (rx_wdata),
    .i_pop   (rx_pop),
    .o_full  (rx_full),
    .o_empty (rx_empty),
    .o_head  (rx_head)
  );

  assign bus.o_pe_tx_ready    = pe_tx_ready;
  assign bus.o_noc_data_ready = noc_in_ready;
  assign bus.o_noc_data_valid = !tx_empty;
  assign bus.o_noc_data       = tx_empty ? '0 : tx_head;
  assign bus.o_pe_rx_valid    = rx_deliver;
  assign bus.o_pe_rx_payload  = rx_deliver ? rx_head[PayloadWidth-1:0] : '0;
  assign bus.o_pe_rx_src_ok   = rx_deliver;
  assign bus.o_misroute_cnt   = misroute_cnt_q;

endmodule

// File: tb/tb_hnoc_pe_adapter.sv
// tb_hnoc_pe_adapter: directed stimulus, a queue-level reference model compared every cycle,
// and literal expectations pinning key cycles.
module tb_hnoc_pe_adapter;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int PW    = DW - AW;
  localparam int DEPTH = 4;
  localparam int MY    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  hnoc_pe_adapter_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

  hnoc_pe_adapter #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .MyAddr    (MY),
    .FifoDepth (DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: two queues of flits, a drop counter and a ready-enable flag.
  logic [DW-1:0] m_tx[$];
  logic [DW-1:0] m_rx[$];
  int            m_cnt = 0;
  bit            m_en = 1'b0;

  function automatic logic [AW-1:0] dest_of(input logic [DW-1:0] f);
    return f[DW-1 -: AW];
  endfunction

  function automatic bit exp_noc_ready();
    return m_en && (m_rx.size() < DEPTH);
  endfunction

  function automatic bit exp_pe_tx_ready();
`ifdef HNOC_LOOPBACK_EN
    if (bus.i_pe_tx_dest == AW'(MY))
      return m_en && (m_rx.size() < DEPTH) && !(bus.i_noc_data_valid && exp_noc_ready());
`endif
    return m_en && (m_tx.size() < DEPTH);
  endfunction

  function automatic bit exp_rx_valid();
    return (m_rx.size() > 0) && (dest_of(m_rx[0]) == AW'(MY));
  endfunction

  function automatic logic [31:0] exp_rx_payload();
    logic [DW-1:0] h;
    if (!exp_rx_valid()) return '0;
    h = m_rx[0];
    return 32'(h[PW-1:0]);
  endfunction

  function automatic logic [31:0] exp_noc_data();
    if (m_tx.size() == 0) return '0;
    return m_tx[0];
  endfunction

  // Inputs change only just after a rising edge, so values seen at the falling edge are exactly
  // what the next rising edge samples: compare first, then advance the model by that edge.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("noc_valid",    32'(bus.o_noc_data_valid), 32'(m_tx.size() > 0));
      check("noc_data",     bus.o_noc_data,            exp_noc_data());
      check("pe_tx_ready",  32'(bus.o_pe_tx_ready),    32'(exp_pe_tx_ready()));
      check("noc_ready",    32'(bus.o_noc_data_ready), 32'(exp_noc_ready()));
      check("rx_valid",     32'(bus.o_pe_rx_valid),    32'(exp_rx_valid()));
      check("rx_payload",   32'(bus.o_pe_rx_payload),  exp_rx_payload());
      check("rx_src_ok",    32'(bus.o_pe_rx_src_ok),   32'(exp_rx_valid()));
      check("misroute_cnt", 32'(bus.o_misroute_cnt),   32'(m_cnt));
    end
    if (!rst_n) begin
      m_tx.delete();
      m_rx.delete();
      m_cnt  = 0;
      m_en   = 1'b0;
      chk_on = 1'b1;
    end else begin
      bit            tx_acc, noc_acc;
      logic [DW-1:0] tx_f;
      tx_acc  = bus.i_pe_tx_valid && exp_pe_tx_ready();
      noc_acc = bus.i_noc_data_valid && exp_noc_ready();
      tx_f    = {bus.i_pe_tx_dest, bus.i_pe_tx_payload};
      if ((m_tx.size() > 0) && bus.i_noc_data_ready) void'(m_tx.pop_front());
      if (m_rx.size() > 0) begin
        if (dest_of(m_rx[0]) != AW'(MY)) begin
          void'(m_rx.pop_front());
          if (m_cnt < 255) m_cnt++;
        end else if (bus.i_pe_rx_ready) begin
          void'(m_rx.pop_front());
        end
      end
      if (noc_acc) m_rx.push_back(bus.i_noc_data);
      if (tx_acc) begin
`ifdef HNOC_LOOPBACK_EN
        if (bus.i_pe_tx_dest == AW'(MY)) m_rx.push_back(tx_f);
        else m_tx.push_back(tx_f);
`else
        m_tx.push_back(tx_f);
`endif
      end
      m_en = 1'b1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.i_pe_tx_payload  = '0;
    bus.i_pe_tx_dest     = '0;
    bus.i_pe_tx_valid    = 1'b0;
    bus.i_noc_data_ready = 1'b0;
    bus.i_noc_data       = '0;
    bus.i_noc_data_valid = 1'b0;
    bus.i_pe_rx_ready    = 1'b0;
    rst_n                = 1'b0;

    // Reset state.
    tick(2);
    @(negedge clk);
    check("rst_noc_valid",  32'(bus.o_noc_data_valid), 32'd0);
    check("rst_rx_valid",   32'(bus.o_pe_rx_valid),    32'd0);
    check("rst_tx_ready",   32'(bus.o_pe_tx_ready),    32'd0);
    check("rst_noc_ready",  32'(bus.o_noc_data_ready), 32'd0);
    check("rst_noc_data",   bus.o_noc_data,            32'd0);
    check("rst_cnt",        32'(bus.o_misroute_cnt),   32'd0);
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_edge", 32'(bus.o_pe_tx_ready), 32'd0);
    tick;
    @(negedge clk);
    check("ready_after_edge", 32'(bus.o_pe_tx_ready), 32'd1);

    // TX: dest 5, payload 0x0ABCDE -> flit 0xA00ABCDE one cycle after acceptance.
    tick;
    bus.i_noc_data_ready = 1'b1;
    bus.i_pe_tx_dest     = 3'd5;
    bus.i_pe_tx_payload  = 29'h0ABCDE;
    bus.i_pe_tx_valid    = 1'b1;
    tick;
    bus.i_pe_tx_valid = 1'b0;
    @(negedge clk);
    check("tx_flit_data",  bus.o_noc_data,             32'hA00ABCDE);
    check("tx_flit_valid", 32'(bus.o_noc_data_valid),  32'd1);
    tick;
    @(negedge clk);
    check("tx_flit_gone",  32'(bus.o_noc_data_valid),  32'd0);

    // RX: local flit delivered, then foreign flit dropped and counted.
    tick;
    bus.i_pe_rx_ready    = 1'b1;
    bus.i_noc_data       = 32'h40000123;
    bus.i_noc_data_valid = 1'b1;
    tick;
    bus.i_noc_data = 32'h60000001;
    @(negedge clk);
    check("rx_local_valid",   32'(bus.o_pe_rx_valid),   32'd1);
    check("rx_local_payload", 32'(bus.o_pe_rx_payload), 32'h123);
    tick;
    bus.i_noc_data_valid = 1'b0;
    @(negedge clk);
    check("rx_misroute_hidden", 32'(bus.o_pe_rx_valid), 32'd0);
    tick;
    @(negedge clk);
    check("rx_misroute_cnt", 32'(bus.o_misroute_cnt), 32'd1);

    // Backpressure: fill the TX FIFO, then drain in order.
    tick;
    bus.i_noc_data_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_pe_tx_dest    = AW'(i + 3);
      bus.i_pe_tx_payload = PW'(32'h100 + 32'(i));
      bus.i_pe_tx_valid   = 1'b1;
      tick;
    end
    bus.i_pe_tx_valid = 1'b0;
    @(negedge clk);
    check("tx_full_ready", 32'(bus.o_pe_tx_ready), 32'd0);
    tick;
    bus.i_noc_data_ready = 1'b1;
    @(negedge clk);
    check("drain_first", bus.o_noc_data, 32'h60000100);
    tick;
    @(negedge clk);
    check("ready_after_pop", 32'(bus.o_pe_tx_ready), 32'd1);
    check("drain_second",    bus.o_noc_data,         32'h80000101);
    tick(2);
    @(negedge clk);
    check("drain_last", bus.o_noc_data, 32'hC0000103);
    tick;
    @(negedge clk);
    check("drain_empty", 32'(bus.o_noc_data_valid), 32'd0);

    // 300 misrouted flits saturate the counter.
    tick;
    bus.i_noc_data       = 32'h60000001;
    bus.i_noc_data_valid = 1'b1;
    tick(300);
    bus.i_noc_data_valid = 1'b0;
    tick(3);
    @(negedge clk);
    check("cnt_saturated", 32'(bus.o_misroute_cnt), 32'd255);

    // Reset with three flits buffered in each direction.
    tick;
    bus.i_noc_data_ready = 1'b0;
    bus.i_pe_rx_ready    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.i_pe_tx_dest     = 3'd4;
      bus.i_pe_tx_payload  = PW'(i);
      bus.i_pe_tx_valid    = 1'b1;
      bus.i_noc_data       = {3'd2, PW'(32'h200 + 32'(i))};
      bus.i_noc_data_valid = 1'b1;
      tick;
    end
    bus.i_pe_tx_valid    = 1'b0;
    bus.i_noc_data_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_rx_payload", 32'(bus.o_pe_rx_payload), 32'h200);
    check("pre_rst_noc_data",   bus.o_noc_data,           32'h80000000);
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_noc_valid", 32'(bus.o_noc_data_valid), 32'd0);
    check("midrst_rx_valid",  32'(bus.o_pe_rx_valid),    32'd0);
    check("midrst_cnt",       32'(bus.o_misroute_cnt),   32'd0);
    tick;
    bus.i_noc_data_ready = 1'b1;
    bus.i_pe_rx_ready    = 1'b1;
    tick(4);
    @(negedge clk);
    check("no_stale_noc", 32'(bus.o_noc_data_valid), 32'd0);
    check("no_stale_rx",  32'(bus.o_pe_rx_valid),    32'd0);

`ifdef HNOC_LOOPBACK_EN
    // Self-addressed TX collides with a NoC arrival: network first, loopback next cycle.
    tick;
    bus.i_pe_tx_dest     = 3'd2;
    bus.i_pe_tx_payload  = 29'h55;
    bus.i_pe_tx_valid    = 1'b1;
    bus.i_noc_data       = 32'h40000077;
    bus.i_noc_data_valid = 1'b1;
    @(negedge clk);
    check("lb_stalled", 32'(bus.o_pe_tx_ready), 32'd0);
    tick;
    bus.i_noc_data_valid = 1'b0;
    @(negedge clk);
    check("lb_noc_first", 32'(bus.o_pe_rx_payload), 32'h77);
    check("lb_ready",     32'(bus.o_pe_tx_ready),   32'd1);
    tick;
    bus.i_pe_tx_valid = 1'b0;
    @(negedge clk);
    check("lb_payload",  32'(bus.o_pe_rx_payload),  32'h55);
    check("lb_no_noc",   32'(bus.o_noc_data_valid), 32'd0);
    tick;
    @(negedge clk);
    check("lb_done", 32'(bus.o_pe_rx_valid), 32'd0);
`endif

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
